// File: rtl/alu_mul_seq_pkg.sv
// alu_mul_seq_pkg: shared ALU opcodes and multiplier sequencer state.
// Used by the execute-stage ALU and the shift-add multiplier sequencer.
package alu_mul_seq_pkg;

   localparam logic [6:0] ALU_ADD = 7'd0;
   localparam logic [6:0] ALU_SUB = 7'd1;
   localparam logic [6:0] ALU_AND = 7'd2;
   localparam logic [6:0] ALU_OR  = 7'd3;
   localparam logic [6:0] ALU_XOR = 7'd4;
   localparam logic [6:0] ALU_SHL = 7'd5;
   localparam logic [6:0] ALU_SHR = 7'd6;

   typedef logic [1:0] seq_state_t;

   localparam seq_state_t ST_IDLE = 2'd0;
   localparam seq_state_t ST_ADD  = 2'd1;
   localparam seq_state_t ST_SHL  = 2'd2;
   localparam seq_state_t ST_DONE = 2'd3;

   // Pick the next state from the multiplier bits still to process.
   function automatic seq_state_t seq_next(input logic [31:0] m);
      if (m == 32'd0)
         return ST_DONE;
      else if (m[0])
         return ST_ADD;
      else
         return ST_SHL;
   endfunction

endpackage

// File: rtl/alu_mul_seq_if.sv
// alu_mul_seq_if: start and result valid/ready handshakes of the sequencer.
// master = requester/consumer side, slave = the sequencer.
interface alu_mul_seq_if;

   logic        start_valid;
   logic        start_ready;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        result_valid;
   logic        result_ready;
   logic [31:0] result;
   logic        busy;

   modport master (
      output start_valid,
      output op_a,
      output op_b,
      output result_ready,
      input  start_ready,
      input  result_valid,
      input  result,
      input  busy
   );

   modport slave (
      input  start_valid,
      input  op_a,
      input  op_b,
      input  result_ready,
      output start_ready,
      output result_valid,
      output result,
      output busy
   );

endinterface

// File: rtl/alu.sv
// alu: shared combinational execute-stage ALU.
// Ports: a, b operands; opcode selects the operation; y result.
import alu_mul_seq_pkg::*;

module alu (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [6:0]  opcode,
   output logic [31:0] y
);

   always_comb begin
      y = 32'd0;
      case (opcode)
         ALU_ADD: y = a + b;
         ALU_SUB: y = a - b;
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_XOR: y = a ^ b;
         ALU_SHL: y = a << b[4:0];
         ALU_SHR: y = a >> b[4:0];
         default: y = 32'd0;
      endcase
   end

endmodule

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add multiplier that borrows the shared ALU.
// Ports: clk, rst_n; bus (start/result handshakes, busy);
// alu_en/alu_a/alu_b/alu_opcode drive the ALU, alu_result returns.
import alu_mul_seq_pkg::*;

module alu_mul_seq (
   input  logic         clk,
   input  logic         rst_n,
   alu_mul_seq_if.slave bus,
   output logic         alu_en,
   output logic [31:0]  alu_a,
   output logic [31:0]  alu_b,
   output logic [6:0]   alu_opcode,
   input  logic [31:0]  alu_result
);

   seq_state_t  state;
   seq_state_t  state_nx;
   logic [31:0] acc;
   logic [31:0] mcand;
   logic [31:0] mplier;
   logic [31:0] mplier_sh;
   logic        accept;

   assign mplier_sh = mplier >> 1;
   assign accept    = (state == ST_IDLE) && bus.start_valid;

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (bus.start_valid) state_nx = seq_next(bus.op_b);
         ST_ADD:  state_nx = ST_SHL;
         ST_SHL:  state_nx = seq_next(mplier_sh);
         ST_DONE: if (bus.result_ready) state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         acc    <= 32'd0;
         mcand  <= 32'd0;
         mplier <= 32'd0;
      end else begin
         state <= state_nx;
         if (accept) begin
            acc    <= 32'd0;
            mcand  <= bus.op_a;
            mplier <= bus.op_b;
         end
         if (state == ST_ADD)
            acc <= alu_result;
         if (state == ST_SHL) begin
            mcand  <= alu_result;
            mplier <= mplier_sh;
         end
      end
   end

   // The ALU sees zeros whenever the sequencer does not own it.
   always_comb begin
      alu_en     = 1'b0;
      alu_a      = 32'd0;
      alu_b      = 32'd0;
      alu_opcode = ALU_ADD;
      unique case (1'b1)
         (state == ST_ADD): begin
            alu_en     = 1'b1;
            alu_opcode = ALU_ADD;
            alu_a      = acc;
            alu_b      = mcand;
         end
         (state == ST_SHL): begin
            alu_en     = 1'b1;
            alu_opcode = ALU_SHL;
            alu_a      = mcand;
            alu_b      = 32'd1;
         end
         default: ;
      endcase
   end

   assign bus.start_ready  = (state == ST_IDLE);
   assign bus.busy         = (state != ST_IDLE);
   assign bus.result_valid = (state == ST_DONE);
   assign bus.result       = acc;

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle shift-add multiplier sequencer that borrows the shared combinational ALU to compute the low 32 bits of a 32×32 product. It sits beside the ALU in the execute datapath. While busy, it drives the ALU operand and opcode inputs through a steering mux selected by `alu_en`, and it reads the ALU result back in the same cycle. Operands come in through a valid/ready start handshake and the product leaves through a valid/ready result handshake.

## Interface
- No parameters; data width is fixed at 32.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_valid` in 1: operands are offered.
- `start_ready` out 1: the sequencer accepts operands (high only in IDLE).
- `op_a` in 32: multiplicand.
- `op_b` in 32: multiplier.
- `result_valid` out 1: the product is available.
- `result_ready` in 1: the consumer takes the product.
- `result` out 32: low 32 bits of `op_a*op_b`.
- `busy` out 1: high in every state except IDLE.
- `alu_en` out 1: the sequencer owns the ALU this cycle (steering mux select).
- `alu_a`, `alu_b` out 32: ALU operands.
- `alu_opcode` out 7: ALU operation (0 = add, 5 = shift left).
- `alu_result` in 32: combinational ALU output for the current `alu_a`/`alu_b`/`alu_opcode`.

## Operation
- Registers:
  - `acc`: running sum.
  - `mcand`: shifted multiplicand.
  - `mplier`: remaining multiplier bits.
  - `state`: one of IDLE, ADD, SHL, DONE.
- **IDLE**
  - `start_ready`=1.
  - On `start_valid`: `acc`←0, `mcand`←`op_a`, `mplier`←`op_b`.
  - Next state: DONE if `op_b`==0; ADD if `op_b[0]`; otherwise SHL.
- **ADD**
  - Drives `alu_en`=1, `alu_opcode`=0, `alu_a`=`acc`, `alu_b`=`mcand`.
  - `acc`←`alu_result`. Next state: SHL.
- **SHL**
  - Drives `alu_en`=1, `alu_opcode`=5, `alu_a`=`mcand`, `alu_b`=1.
  - `mcand`←`alu_result`, `mplier`←`mplier>>1` (local shift).
  - Let m = `mplier>>1`. Next state: DONE if m==0; ADD if m[0]; otherwise SHL.
- **DONE**
  - `result_valid`=1, `result`=`acc`.
  - On `result_ready` → IDLE.
- ADD is entered only when the current multiplier bit is 1; zero bits cost a single SHL cycle.
- Arithmetic wraps modulo 2^32. Only the low 32 bits are produced, so signed and unsigned operands give the same result. There is no overflow flag.
- `start_valid` outside IDLE is ignored (`start_ready`=0). Operands are captured only at acceptance; later changes to `op_a`/`op_b` have no effect.
- `result` holds `acc` while `result_valid` is low. It is meaningful only when `result_valid`=1.
- In IDLE and DONE the ALU outputs are `alu_en`=0 and `alu_a`=`alu_b`=`alu_opcode`=0.

## Timing
- Reset value of every output: `start_ready`=1 (IDLE); `busy`=0; `result_valid`=0; `result`=0; `alu_en`=0; `alu_a`=`alu_b`=0; `alu_opcode`=0. Internal registers clear to 0.
- Accept cycle is cycle 0. Let k = index of the MSB of `op_b` and p = popcount(`op_b`).
  - `result_valid` rises in cycle k+p+2.
  - `op_b`=0 gives `result_valid` in cycle 1.
  - Worst case (`op_b`=0xFFFFFFFF) gives `result_valid` in cycle 65.
- All ALU outputs are pure decodes of `state` and registers. `alu_result` is sampled at the clock edge that ends the same cycle.
- DONE holds until `result_ready`. With `result_ready` high, DONE lasts exactly one cycle.
- The earliest next accept is the cycle after DONE exits. There is no DONE→busy bypass, so throughput is at most one operation per k+p+3 cycles.
- Reset asserted mid-operation: immediate return to IDLE, all outputs to reset values, and the partial product is discarded.

## Structure
- A shared package holds:
  - ALU opcode constants `ALU_ADD`=7'd0, `ALU_SUB`, `ALU_AND`, `ALU_OR`, `ALU_XOR`, `ALU_SHL`=7'd5, `ALU_SHR`=7'd6, which the ALU and this block both use.
  - The sequencer state typedef (2-bit: IDLE, ADD, SHL, DONE).
- No sub-module. The ALU stays external and is shared through the `alu_en` steering mux in the parent datapath.
- The testbench instantiates the real ALU connected to `alu_a`, `alu_b`, `alu_opcode` and `alu_result`.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles → `start_ready`=1, `busy`=0, `result_valid`=0, `alu_en`=0.
- `op_a`=5, `op_b`=3, `result_ready`=1 → state sequence ADD, SHL, ADD, SHL; `result_valid` in cycle 5 with `result`=15; `start_ready` high again in cycle 6.
- `op_a`=7, `op_b`=0 → `result_valid` in cycle 1, `result`=0, `alu_en` never asserted.
- `op_a`=0xFFFFFFFD (-3), `op_b`=7 → `result`=0xFFFFFFEB in cycle 7. Then `op_a`=0x80000000, `op_b`=2 → `result`=0 (wrap) in cycle 4.
- `op_a`=9, `op_b`=4, `result_ready` held low for 5 cycles → `result_valid` stays high with `result`=36 throughout. `start_valid` pulsed during that window is not accepted. Releasing `result_ready` → IDLE next cycle.
- `op_a`=1, `op_b`=0xFFFFFFFF, with `rst_n` pulsed low at cycle 20 → outputs return to reset values immediately. A new request `op_a`=6, `op_b`=5 then yields `result`=30 in cycle 6.
